// File: rtl/mips_cpu_muldiv_ctrl.sv
// mips_cpu_muldiv_ctrl: HI/LO multiply-divide sequencer with pipeline stall generation
module mips_cpu_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             mf_req,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi_reg,
  output logic [WIDTH-1:0] lo_reg
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_n;
  logic [CW-1:0] count;
  logic is_div, neg_q, neg_r;
  logic [WIDTH:0] hr;
  logic [WIDTH-1:0] lr, br;
  logic sgn, ge;
  logic [WIDTH-1:0] a_mag, b_mag, quo_fix, rem_fix;
  logic [WIDTH:0] sum, mval, rem_s, rem_d;
  logic [2*WIDTH-1:0] prod, prod_fix;
  assign busy  = state != IDLE;
  assign stall = busy & (start | mthi | mtlo | mf_req);
  // operand magnitudes, one iteration of each algorithm, and final sign correction
  always_comb begin
    sgn      = ~op[0];
    a_mag    = (sgn & a[WIDTH-1]) ? -a : a;
    b_mag    = (sgn & b[WIDTH-1]) ? -b : b;
    sum      = hr + {1'b0, br};
    mval     = lr[0] ? sum : hr;
    rem_s    = {hr[WIDTH-1:0], lr[WIDTH-1]};
    rem_d    = rem_s - {1'b0, br};
    ge       = rem_s >= {1'b0, br};
    prod     = {hr[WIDTH-1:0], lr};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -lr : lr;
    rem_fix  = neg_r ? -hr[WIDTH-1:0] : hr[WIDTH-1:0];
  end
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_n;
  // next-state: WIDTH iterations in RUN, then one commit cycle
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? RUN : IDLE;
      RUN:     state_n = (count == CW'(WIDTH - 1)) ? FIX : RUN;
      default: state_n = IDLE;
    endcase
  end
  // shared shift registers, HI/LO commit and moves
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      count  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hr     <= '0;
      lr     <= '0;
      br     <= '0;
      done   <= 1'b0;
      hi_reg <= '0;
      lo_reg <= '0;
    end else begin
      done <= state == FIX;
      case (state)
        IDLE:
          if (start) begin
            is_div <= op[1];
            neg_q  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= sgn & a[WIDTH-1];
            hr     <= '0;
            lr     <= a_mag;
            br     <= b_mag;
            count  <= '0;
          end else begin
            if (mthi) hi_reg <= wdata;
            if (mtlo) lo_reg <= wdata;
          end
        RUN: begin
          count <= count + 1'b1;
          if (is_div) begin
            hr <= ge ? rem_d : rem_s;
            lr <= {lr[WIDTH-2:0], ge};
          end else begin
            hr <= {1'b0, mval[WIDTH:1]};
            lr <= {mval[0], lr[WIDTH-1:1]};
          end
        end
        default:
          if (!is_div) {hi_reg, lo_reg} <= prod_fix;
          else if (br != '0) begin
            lo_reg <= quo_fix;
            hi_reg <= rem_fix;
          end
      endcase
    end
endmodule

// File: tb/tb_mips_cpu_muldiv_ctrl.sv
// tb_mips_cpu_muldiv_ctrl: directed checks of the HI/LO multiply-divide sequencer
module tb_mips_cpu_muldiv_ctrl;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, mthi = 1'b0, mtlo = 1'b0, mf_req = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic busy, stall, done;
  logic [31:0] hi_reg, lo_reg;
  int n_chk = 0, n_err = 0;
  int n;
  mips_cpu_muldiv_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .mf_req(mf_req),
    .busy(busy), .stall(stall), .done(done), .hi_reg(hi_reg), .lo_reg(lo_reg)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!done && cycles < 40);
  endtask
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int c;
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(c);
    chk({tag, "_lat"}, 32'(c), 32'd33);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_hi"}, hi_reg, exp_hi);
    chk({tag, "_lo"}, lo_reg, exp_lo);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    tick();
    chk({tag, "_pulse"}, 32'(done), 32'd0);
  endtask
  initial begin
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi_reg, 32'd0);
    chk("rst_lo", lo_reg, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    do_op("mult_neg", 2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    do_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    do_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("divu", 2'b11, 32'd7, 32'd2, 32'd1, 32'd3);
    mthi = 1'b1; wdata = 32'h1234;
    #1 chk("mthi_nostall", 32'(stall), 32'd0);
    tick();
    mthi = 1'b0; mtlo = 1'b1; wdata = 32'h5678;
    tick();
    mtlo = 1'b0;
    chk("mthi_hi", hi_reg, 32'h1234);
    chk("mtlo_lo", lo_reg, 32'h5678);
    do_op("div_zero", 2'b10, 32'd99, 32'd0, 32'h1234, 32'h5678);
    do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    mf_req = 1'b1;
    #1 chk("mf_stall", 32'(stall), 32'd1);
    mf_req = 1'b0; mthi = 1'b1; wdata = 32'hFFFF_FFFF;
    #1 chk("mthi_stall", 32'(stall), 32'd1);
    tick();
    mthi = 1'b0;
    chk("run_hi_kept", hi_reg, 32'h0000_0000);
    chk("run_lo_kept", lo_reg, 32'h8000_0000);
    a = 32'd4; b = 32'd5; start = 1'b1;
    #1 chk("start_stall", 32'(stall), 32'd1);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk("b2b_done1", 32'(done), 32'd1);
    chk("b2b_lo1", lo_reg, 32'd6);
    chk("b2b_hi1", hi_reg, 32'd0);
    chk("b2b_nostall", 32'(stall), 32'd0);
    tick();
    start = 1'b0;
    chk("b2b_accept", 32'(busy), 32'd1);
    wait_done(n);
    chk("b2b_lat2", 32'(n), 32'd33);
    chk("b2b_lo2", lo_reg, 32'd20);
    tick();
    mthi = 1'b1; wdata = 32'hAAAA;
    tick();
    mthi = 1'b0;
    op = 2'b01; a = 32'd9; b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi_reg, 32'd0);
    chk("abort_lo", lo_reg, 32'd0);
    #1 reset = 1'b1;
    tick();
    do_op("post_rst", 2'b01, 32'd3, 32'd5, 32'd0, 32'd15);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
